// File: rtl/regfile_clr_pkg.sv
// Shared register-file constants: bus widths, enable levels and the
// two-state encoding of the clear/run sequencer.
package regfile_clr_pkg;

    localparam int RegBus     = 32;
    localparam int RegNumLog2 = 5;
    localparam int RegAddrBus = RegNumLog2;
    localparam int RegNum     = 2 ** RegNumLog2;

    localparam logic [RegBus-1:0]     ZeroWord   = '0;
    localparam logic [RegAddrBus-1:0] NOPRegAddr = '0;

    localparam logic RstEnable   = 1'b1;
    localparam logic WriteEnable = 1'b1;
    localparam logic ReadEnable  = 1'b1;

    localparam logic [0:0] RfStateClear = 1'b0;
    localparam logic [0:0] RfStateRun   = 1'b1;

endpackage

// File: rtl/regfile_clr_rf_read_port.sv
// One register-file read port: a combinational priority mux that blanks the
// output while the file is unavailable, hardwires $0 to zero and forwards a
// write presented in the same cycle ahead of the stored word.
module regfile_clr_rf_read_port
    import regfile_clr_pkg::*;
#(
    parameter int DATA_W = RegBus,
    parameter int ADDR_W = RegAddrBus
) (
    input  logic              busy_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [DATA_W-1:0] word_i,
    output logic [DATA_W-1:0] rdata_o
);

    // Priority order: busy, disabled, $0, same-cycle bypass, stored word.
    always_comb begin
        rdata_o = DATA_W'(ZeroWord);
        if (busy_i) begin
            rdata_o = DATA_W'(ZeroWord);
        end else if (re_i != ReadEnable) begin
            rdata_o = DATA_W'(ZeroWord);
        end else if (raddr_i == ADDR_W'(NOPRegAddr)) begin
            rdata_o = DATA_W'(ZeroWord);
        end else if ((we_i == WriteEnable) && (waddr_i == raddr_i)) begin
            rdata_o = wdata_i;
        end else begin
            rdata_o = word_i;
        end
    end

endmodule

// File: rtl/regfile_clr.sv
// General-purpose register file with two bypassing read ports, one write
// port, $0 hardwired to zero, and a hardware clear of $1..$N-1 that runs
// one register per cycle after every reset.
module regfile_clr
    import regfile_clr_pkg::*;
#(
    parameter int DATA_W   = RegBus,
    parameter int ADDR_W   = RegAddrBus,
    parameter int NUM_REGS = RegNum
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic              init_busy,
    output logic              init_done
);

    logic [DATA_W-1:0] mem_q [NUM_REGS];

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] clrIdx_q, clrIdx_d;
    logic              initDone_q, initDone_d;

    logic              clearing;
    logic              readBlocked;
    logic [DATA_W-1:0] word1, word2;

    assign clearing    = (state_q == RfStateClear);
    assign readBlocked = (rst == RstEnable) || clearing;
    assign init_busy   = clearing;
    assign init_done   = initDone_q;

    // Sequencer next state: walk clrIdx across the file, then enter RUN with
    // a one-cycle done pulse.
    always_comb begin
        state_d    = state_q;
        clrIdx_d   = clrIdx_q;
        initDone_d = 1'b0;
        if (state_q == RfStateClear) begin
            clrIdx_d = clrIdx_q + ADDR_W'(1);
            if (clrIdx_q == ADDR_W'(NUM_REGS - 1)) begin
                state_d    = RfStateRun;
                initDone_d = 1'b1;
            end
        end
    end

    // Sequencer registers; reset restarts the clear from $1.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q    <= RfStateClear;
            clrIdx_q   <= ADDR_W'(1);
            initDone_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clrIdx_q   <= clrIdx_d;
            initDone_q <= initDone_d;
        end
    end

    // Storage: the clear owns the write port while it runs, external writes
    // are dropped then; $0 is never written and never read.
    always_ff @(posedge clk) begin
        if (rst != RstEnable) begin
            if (clearing) begin
                mem_q[clrIdx_q] <= DATA_W'(ZeroWord);
            end else if ((we == WriteEnable) && (waddr != ADDR_W'(NOPRegAddr))) begin
                mem_q[waddr] <= wdata;
            end
        end
    end

    assign word1 = mem_q[raddr1];
    assign word2 = mem_q[raddr2];

    regfile_clr_rf_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_port1 (
        .busy_i  (readBlocked),
        .re_i    (re1),
        .raddr_i (raddr1),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (wdata),
        .word_i  (word1),
        .rdata_o (rdata1)
    );

    regfile_clr_rf_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_port2 (
        .busy_i  (readBlocked),
        .re_i    (re2),
        .raddr_i (raddr2),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (wdata),
        .word_i  (word2),
        .rdata_o (rdata2)
    );

    // Debug view of the stored contents, deliberately without bypass.
    always_comb begin
        dbg_data = DATA_W'(ZeroWord);
        if (!readBlocked && (dbg_addr != ADDR_W'(NOPRegAddr))) begin
            dbg_data = mem_q[dbg_addr];
        end
    end

endmodule

// File: tb/tb_regfile_clr.sv
// Self-checking bench for regfile_clr: directed clear/bypass/$0/reset
// scenarios plus a randomized RUN phase against an array reference model.
module tb_regfile_clr;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic        init_busy;
    logic        init_done;

    logic [31:0] model [32];
    logic        expDone;
    int          nChecks;
    int          nFails;
    int          clearCycles;

    regfile_clr dut (
        .clk       (clk),
        .rst       (rst),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .re1       (re1),
        .raddr1    (raddr1),
        .rdata1    (rdata1),
        .re2       (re2),
        .raddr2    (raddr2),
        .rdata2    (rdata2),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data),
        .init_busy (init_busy),
        .init_done (init_done)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference read rule for one port in RUN.
    function automatic logic [31:0] expRead(input logic ren, input logic [4:0] addr);
        if (!ren || addr == 5'd0) return 32'h0;
        if (we && waddr == addr) return wdata;
        return model[addr];
    endfunction

    function automatic logic [31:0] expDbg(input logic [4:0] addr);
        if (addr == 5'd0) return 32'h0;
        return model[addr];
    endfunction

    // One RUN cycle: drive, check combinational outputs, clock, update model.
    task automatic applyStimulus(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                                 input logic r1, input logic [4:0] a1,
                                 input logic r2, input logic [4:0] a2,
                                 input logic [4:0] da);
        we = w; waddr = wa; wdata = wd;
        re1 = r1; raddr1 = a1; re2 = r2; raddr2 = a2; dbg_addr = da;
        #2;
        checkOutput("rdata1", rdata1, expRead(r1, a1));
        checkOutput("rdata2", rdata2, expRead(r2, a2));
        checkOutput("dbg_data", dbg_data, expDbg(da));
        checkOutput("run_busy", {31'b0, init_busy}, 32'h0);
        checkOutput("run_done", {31'b0, init_done}, {31'b0, expDone});
        @(posedge clk);
        if (w && wa != 5'd0) model[wa] = wd;
        expDone = 1'b0;
        #1;
    endtask

    // Reset with a write and reads presented in the reset cycle.
    task automatic doReset(input logic [4:0] wa, input logic [31:0] wd);
        rst = 1'b1; we = 1'b1; waddr = wa; wdata = wd;
        re1 = 1'b1; raddr1 = wa; re2 = 1'b1; raddr2 = wa; dbg_addr = wa;
        #2;
        checkOutput("rst_rdata1", rdata1, 32'h0);
        checkOutput("rst_rdata2", rdata2, 32'h0);
        checkOutput("rst_dbg", dbg_data, 32'h0);
        @(posedge clk);
        #1;
        checkOutput("rst_busy", {31'b0, init_busy}, 32'h1);
        checkOutput("rst_done", {31'b0, init_done}, 32'h0);
        rst = 1'b0; we = 1'b0;
    endtask

    // Run the clear with random traffic; optional write at weAt and reset at rstAt.
    task automatic runClear(input int rstAt, input int weAt, output int cycles);
        int pendingRst;
        int guard;
        pendingRst = rstAt;
        cycles = 0;
        guard = 0;
        while (init_busy === 1'b1 && guard < 200) begin
            guard++;
            re1 = 1'($urandom); raddr1 = 5'($urandom_range(1, 31));
            re2 = 1'($urandom); raddr2 = 5'($urandom_range(1, 31));
            dbg_addr = 5'($urandom);
            we = (cycles == weAt) ? 1'b1 : 1'($urandom);
            waddr = (cycles == weAt) ? 5'd3 : 5'($urandom);
            wdata = (cycles == weAt) ? 32'hA5A5A5A5 : $urandom;
            if (cycles == pendingRst) rst = 1'b1;
            #2;
            checkOutput("clr_rdata1", rdata1, 32'h0);
            checkOutput("clr_rdata2", rdata2, 32'h0);
            checkOutput("clr_dbg", dbg_data, 32'h0);
            checkOutput("clr_done", {31'b0, init_done}, 32'h0);
            @(posedge clk);
            #1;
            if (rst) begin
                rst = 1'b0;
                cycles = 0;
                pendingRst = -1;
            end else begin
                cycles++;
            end
        end
        we = 1'b0;
        checkOutput("clear_len", cycles, 31);
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        expDone = 1'b1;
    endtask

    initial begin
        nChecks = 0;
        nFails = 0;
        expDone = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
        re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0; dbg_addr = '0;
        @(posedge clk);
        #1;

        // Power-on reset and clear, with a write offered on clear cycle 10.
        doReset(5'd9, 32'h0BAD_0BAD);
        runClear(-1, 10, clearCycles);

        // First RUN cycle: done pulse, $3 must still be zero.
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b1, 5'd9, 5'd3);
        for (int a = 1; a < 32; a++) begin
            dbg_addr = 5'(a);
            #1;
            checkOutput("dbg_cleared", dbg_data, 32'h0);
        end

        // Write then read, then read disabled.
        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd0, 5'd5);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd5, 5'd5);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 1'b0, 5'd5, 5'd5);

        // Same-cycle bypass on both ports; debug shows the old value.
        applyStimulus(1'b1, 5'd7, 32'h12345678, 1'b1, 5'd7, 1'b1, 5'd7, 5'd7);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b1, 5'd7, 5'd7);

        // $0 hardwire.
        applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 1'b1, 5'd0, 5'd0);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b1, 5'd0, 5'd0);

        // Randomized traffic, addresses biased low to provoke bypass hits.
        for (int n = 0; n < 300; n++) begin
            logic [4:0] wa, a1, a2;
            wa = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            a1 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            a2 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            applyStimulus(1'($urandom), wa, $urandom, 1'($urandom), a1,
                          1'($urandom), a2, 5'($urandom));
        end

        // Reset in the middle of the clear restarts it for a full length.
        doReset(5'd4, 32'h44444444);
        runClear(15, -1, clearCycles);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b1, 5'd5, 5'd31);

        // Reset in RUN drops the presented write and re-clears $31.
        applyStimulus(1'b1, 5'd31, 32'h1, 1'b0, 5'd0, 1'b0, 5'd0, 5'd31);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd31, 1'b0, 5'd0, 5'd31);
        doReset(5'd12, 32'hCAFEF00D);
        runClear(-1, -1, clearCycles);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd31, 1'b1, 5'd12, 5'd31);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 1'b1, 5'd31, 5'd12);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
